// File: rtl/avr_cpu_stack_pkg.sv
// avr_cpu_stack_pkg: PC width and hardware stack depth shared with the PC logic
package avr_cpu_stack_pkg;
    localparam int PC_WIDTH       = 9;
    localparam int HW_STACK_DEPTH = 3;
endpackage

// File: rtl/avr_cpu_stack.sv
// avr_cpu_stack: LIFO return-address stack (entry 0 = TOS); ports clk, rst (async low), read/write, data (shared bus), empty/full, sticky ovf/unf
module avr_cpu_stack
    import avr_cpu_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = HW_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read,
    input  logic             write,
    inout  wire  [WIDTH-1:0] data,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buffer [DEPTH];
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign push  = write && !read;
    assign pop   = read && !write;
    assign data  = pop ? buffer[0] : 'z;
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            buffer[0] <= data;
            for (int i = 1; i < DEPTH; i++) buffer[i] <= buffer[i-1];
            if (full) ovf <= 1'b1;
            else count <= count + 1'b1;
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) buffer[i] <= buffer[i+1];
            if (empty) unf <= 1'b1;
            else count <= count - 1'b1;
        end
endmodule

// File: tb/tb_avr_cpu_stack.sv
// tb_avr_cpu_stack: directed vectors against a queue model of the return-address stack
module tb_avr_cpu_stack;
    logic       clk;
    logic       rst;
    logic       read;
    logic       write;
    logic [8:0] tb_val;
    logic       tb_en;
    wire  [8:0] data;
    logic       empty, full, ovf, unf;
    int         errors = 0;
    int         checks = 0;

    logic [8:0] m_q[$];
    int         m_cnt;
    logic       m_ovf, m_unf;

    assign data = tb_en ? tb_val : 'z;

    avr_cpu_stack dut (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .data(data), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    initial begin
        clk = 0;
        #2;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst)
        if (!rst) begin
            m_q = '{9'd0, 9'd0, 9'd0};
            m_cnt = 0;
            m_ovf = 0;
            m_unf = 0;
        end else if (write && !read) begin
            m_q.push_front(tb_val);
            void'(m_q.pop_back());
            if (m_cnt == 3) m_ovf = 1;
            else m_cnt++;
        end else if (read && !write) begin
            m_q.push_back(m_q[2]);
            void'(m_q.pop_front());
            if (m_cnt == 0) m_unf = 1;
            else m_cnt--;
        end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("empty", int'(empty), int'(m_cnt == 0));
        chk("full", int'(full), int'(m_cnt == 3));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("unf", int'(unf), int'(m_unf));
        if (read && !write) chk("bus_tos", int'(data), int'(m_q[0]));
        else if (tb_en) chk("bus_released", int'(data), int'(tb_val));
    end

    task automatic drive(input logic r, input logic w, input logic [8:0] v);
        read   = r;
        write  = w;
        tb_val = v;
        tb_en  = !(r && !w);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] v);
        drive(0, 1, v);
        tick();
    endtask

    task automatic pop_expect(input string name, input int exp);
        drive(1, 0, 0);
        #1;
        chk(name, int'(data), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0;
        drive(0, 0, 0);
        #15;
        rst = 1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_unf", int'(unf), 0);
        tick();

        push(1); push(2); push(3);
        chk("t2_full", int'(full), 1);
        pop_expect("t2_pop3", 3);
        pop_expect("t2_pop2", 2);
        pop_expect("t2_pop1", 1);
        drive(0, 0, 0);
        #1;
        chk("t2_empty", int'(empty), 1);
        tick();

        push(1); push(2); push(3); push(4);
        chk("t3_full", int'(full), 1);
        chk("t3_ovf", int'(ovf), 1);
        pop_expect("t3_pop4", 4);
        pop_expect("t3_pop3", 3);
        pop_expect("t3_pop2", 2);
        chk("t3_empty", int'(empty), 1);
        chk("t3_unf", int'(unf), 0);

        pop_expect("t4_stale", 2);
        drive(0, 0, 0);
        #1;
        chk("t4_unf", int'(unf), 1);
        chk("t4_empty", int'(empty), 1);
        tick();

        push(7); push(8);
        drive(1, 1, 0);
        #1;
        chk("t5_bus_released", int'(data), 0);
        tick();
        chk("t5_empty", int'(empty), 0);
        chk("t5_full", int'(full), 0);
        pop_expect("t5_pop8", 8);
        pop_expect("t5_pop7", 7);
        chk("t5_empty_after", int'(empty), 1);

        push(5); push(6);
        drive(0, 0, 0);
        #2;
        rst = 0;
        #1;
        chk("t6_async_empty", int'(empty), 1);
        chk("t6_async_ovf", int'(ovf), 0);
        chk("t6_async_unf", int'(unf), 0);
        tick();
        #2;
        rst = 1;
        tick();
        pop_expect("t6_pop_zero", 0);
        drive(0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end
endmodule
